// File: rtl/fp_alu_sequencer_pkg.sv
// fp_alu_pkg: constants and state encoding shared by the fp_alu sequencer
// and anything that talks to fp_alu.
//   OP_*     : fp_alu opcodes (values above OP_DIV are illegal)
//   QNAN     : canonical quiet NaN returned for illegal opcodes
//   state_e  : sequencer FSM states
package fp_alu_pkg;
  localparam logic [2:0]  OP_ADD = 3'b000;
  localparam logic [2:0]  OP_SUB = 3'b001;
  localparam logic [2:0]  OP_MUL = 3'b010;
  localparam logic [2:0]  OP_DIV = 3'b011;
  localparam logic [31:0] QNAN   = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_RESP
  } state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_DIV;
  endfunction
endpackage

// File: rtl/fp_alu_sequencer_if.sv
// Request/response streams between the command front end and the sequencer.
//   req_*  : valid/ready request (operands + opcode), front end -> sequencer
//   rsp_*  : valid/ready response (result + flags), sequencer -> front end
//   master : front end side;  slave : sequencer side
interface fp_alu_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [2:0]  req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_invalid;
  logic        rsp_timeout;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_invalid, rsp_timeout
  );
  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_invalid, rsp_timeout
  );
endinterface

// File: rtl/fp_alu_sequencer.sv
// fp_alu_sequencer: initiator side of the fp_alu start/ready protocol.
// Takes one request at a time, launches it on fp_alu with a single-cycle
// start pulse, waits for completion (or times out) and returns the result.
// Ports:
//   clk, reset     : clock, async active-low reset
//   bus (slave)    : request / response streams
//   alu_start      : one-cycle start pulse to fp_alu
//   alu_operand_*  : operands / opcode held stable for the whole operation
//   alu_opcode
//   alu_ready      : fp_alu idle/done
//   alu_result     : fp_alu result, alu_invalid : fp_alu invalid flag
//   ops_issued     : wrapping count of start pulses
module fp_alu_sequencer
  import fp_alu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  fp_alu_sequencer_if.slave    bus,
  output logic                 alu_start,
  output logic [31:0]          alu_operand_a,
  output logic [31:0]          alu_operand_b,
  output logic [2:0]           alu_opcode,
  input  logic                 alu_ready,
  input  logic [31:0]          alu_result,
  input  logic                 alu_invalid,
  output logic [CNT_W-1:0]     ops_issued
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_e            state_q, state_d;
  logic [31:0]       a_q, a_d, b_q, b_d, res_q, res_d;
  logic [2:0]        op_q, op_d;
  logic              inv_q, inv_d, to_q, to_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]  ops_q, ops_d;
  logic              req_rdy, start, tmo;

  // >= rather than == so a counter that slips past the limit still aborts.
  assign tmo = (cnt_q >= TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    inv_d   = inv_q;
    to_d    = to_q;
    cnt_d   = cnt_q;
    ops_d   = ops_q;
    req_rdy = 1'b0;
    start   = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_rdy = alu_ready;
        if (bus.req_valid && alu_ready) begin
          a_d  = bus.req_a;
          b_d  = bus.req_b;
          op_d = bus.req_op;
          if (!op_legal(bus.req_op)) begin
            res_d   = QNAN;
            inv_d   = 1'b1;
            to_d    = 1'b0;
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d = '0;
        // Gate on alu_ready so a start can never hit a busy fp_alu.
        if (alu_ready) begin
          start   = 1'b1;
          ops_d   = ops_q + CNT_W'(1);
          state_d = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        cnt_d = cnt_q + TW'(1);
        // Seeing the ack is not completion, so the timeout takes priority.
        if (tmo) begin
          res_d = '0; inv_d = 1'b1; to_d = 1'b1; state_d = S_RESP;
        end else if (!alu_ready) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        cnt_d = cnt_q + TW'(1);
        // Completion wins over a timeout landing in the same cycle.
        if (alu_ready) begin
          res_d = alu_result; inv_d = alu_invalid; to_d = 1'b0; state_d = S_RESP;
        end else if (tmo) begin
          res_d = '0; inv_d = 1'b1; to_d = 1'b1; state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      inv_q   <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      inv_q   <= inv_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
      ops_q   <= ops_d;
    end
  end

  // req_ready is combinational from alu_ready; masking with reset keeps
  // every output low while reset is held.
  assign bus.req_ready   = req_rdy & reset;
  assign bus.rsp_valid   = (state_q == S_RESP);
  assign bus.rsp_result  = res_q;
  assign bus.rsp_invalid = inv_q;
  assign bus.rsp_timeout = to_q;
  assign alu_start       = start;
  assign alu_operand_a   = a_q;
  assign alu_operand_b   = b_q;
  assign alu_opcode      = op_q;
  assign ops_issued      = ops_q;
endmodule

// File: tb/tb_fp_alu_sequencer.sv
module tb_fp_alu_sequencer;
  import fp_alu_pkg::*;
  localparam int TMO = 8;
  localparam int CW  = 3;

  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;

  fp_alu_sequencer_if bus();
  logic          alu_start, alu_invalid = 1'b0, alu_ready = 1'b1;
  logic [31:0]   alu_operand_a, alu_operand_b, alu_result = '0;
  logic [2:0]    alu_opcode;
  logic [CW-1:0] ops_issued;

  fp_alu_sequencer #(.TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .alu_start(alu_start), .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
    .alu_opcode(alu_opcode), .alu_ready(alu_ready), .alu_result(alu_result),
    .alu_invalid(alu_invalid), .ops_issued(ops_issued)
  );

  typedef struct {
    string       name;
    logic [31:0] a, b;
    logic [2:0]  op;
    logic [31:0] res;
    logic        inv, to;
    int          starts;
  } vec_t;

  vec_t          sb_q[$];
  vec_t          vecs[5];
  vec_t          mon_e, v_sub, v_mul, v_add, v_tmo;
  int            tests = 0, fails = 0, start_cnt = 0, busy = 0, base, n;
  bit            hang = 1'b0;
  logic [31:0]   seen_a, seen_b;
  logic [2:0]    seen_op;
  logic [CW-1:0] exp_ops = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Stand-in fp_alu: small lookup of known operations, fixed busy time.
  function automatic logic [32:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == OP_DIV && b == 32'h0) return {32'h7F80_0000, 1'b1};
    case ({op, a, b})
      {OP_ADD, 32'h4060_0000, 32'h4010_0000}: return {32'h40B8_0000, 1'b0};
      {OP_SUB, 32'h4120_0000, 32'h4040_0000}: return {32'h40E0_0000, 1'b0};
      {OP_MUL, 32'h4020_0000, 32'h4080_0000}: return {32'h4120_0000, 1'b0};
      {OP_DIV, 32'h4120_0000, 32'h4000_0000}: return {32'h40A0_0000, 1'b0};
      default: return {32'hDEAD_BEEF, 1'b0};
    endcase
  endfunction

  always @(posedge clk) begin
    if (alu_start && alu_ready) begin
      alu_ready <= 1'b0;
      busy      <= 2;
      {alu_result, alu_invalid} <= alu_fn(alu_opcode, alu_operand_a, alu_operand_b);
      seen_a  <= alu_operand_a;
      seen_b  <= alu_operand_b;
      seen_op <= alu_opcode;
    end else if (!alu_ready && !hang) begin
      if (busy == 0) alu_ready <= 1'b1;
      else busy <= busy - 1;
    end
  end

  // Monitor: counts start pulses and checks responses against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      if (alu_start) begin
        start_cnt++;
        chk("start_needs_alu_ready", alu_ready, 1);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        chk("rsp_expected", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          chk({mon_e.name, "_result"},  bus.rsp_result,  mon_e.res);
          chk({mon_e.name, "_invalid"}, bus.rsp_invalid, mon_e.inv);
          chk({mon_e.name, "_timeout"}, bus.rsp_timeout, mon_e.to);
        end
      end
    end
  end

  task automatic wait_accept(input bit hold);
    int k = 0;
    do begin @(negedge clk); k++; end while (!bus.req_ready && k < 200);
    if (!bus.req_ready) chk("accept_timeout", bus.req_ready, 1);
    @(posedge clk); #1;
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic send(input vec_t v, input bit hold);
    bus.req_a = v.a; bus.req_b = v.b; bus.req_op = v.op; bus.req_valid = 1'b1;
    sb_q.push_back(v);
    wait_accept(hold);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (sb_q.size() != 0 && k < 200) begin @(negedge clk); k++; end
    if (sb_q.size() != 0) chk("drain_timeout", sb_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_fields"}, {bus.rsp_result, bus.rsp_invalid, bus.rsp_timeout}, 0);
    chk({tag, "_alu_start"}, alu_start, 0);
    chk({tag, "_alu_bus"}, {alu_operand_a, alu_operand_b, alu_opcode}, 0);
    chk({tag, "_ops_issued"}, ops_issued, 0);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0; bus.req_op = '0;
    bus.rsp_ready = 1'b1;
    v_add = '{"add", 32'h4060_0000, 32'h4010_0000, OP_ADD, 32'h40B8_0000, 1'b0, 1'b0, 1};
    v_sub = '{"sub", 32'h4120_0000, 32'h4040_0000, OP_SUB, 32'h40E0_0000, 1'b0, 1'b0, 1};
    v_mul = '{"mul", 32'h4020_0000, 32'h4080_0000, OP_MUL, 32'h4120_0000, 1'b0, 1'b0, 1};
    v_tmo = '{"tmo", 32'h4060_0000, 32'h4010_0000, OP_ADD, 32'h0,        1'b1, 1'b1, 1};
    vecs[0] = v_add;
    vecs[1] = '{"div0",  32'h4020_0000, 32'h0000_0000, OP_DIV, 32'h7F80_0000, 1'b1, 1'b0, 1};
    vecs[2] = '{"div",   32'h4120_0000, 32'h4000_0000, OP_DIV, 32'h40A0_0000, 1'b0, 1'b0, 1};
    vecs[3] = '{"ill7",  32'h4060_0000, 32'h4010_0000, 3'b111, QNAN,          1'b1, 1'b0, 0};
    vecs[4] = '{"ill4",  32'h3F80_0000, 32'h3F80_0000, 3'b100, QNAN,          1'b1, 1'b0, 0};

    #12;
    chk_all_zero("reset");
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      base = start_cnt;
      send(vecs[i], 1'b0);
      wait_drain();
      chk({vecs[i].name, "_starts"}, start_cnt - base, vecs[i].starts);
      if (vecs[i].starts == 1)
        chk({vecs[i].name, "_alu_bus"}, {seen_a, seen_b, seen_op}, {vecs[i].a, vecs[i].b, vecs[i].op});
      exp_ops = exp_ops + CW'(vecs[i].starts);
      chk({vecs[i].name, "_ops_issued"}, ops_issued, exp_ops);
    end

    // Back-to-back with req_valid held, first response back-pressured.
    base = start_cnt;
    bus.rsp_ready = 1'b0;
    send(v_sub, 1'b1);
    bus.req_a = v_mul.a; bus.req_b = v_mul.b; bus.req_op = v_mul.op;
    sb_q.push_back(v_mul);
    n = 0;
    do begin @(negedge clk); chk("b2b_req_ready_low", bus.req_ready, 0); n++; end
      while (!bus.rsp_valid && n < 50);
    chk("b2b_first_rsp", bus.rsp_valid, 1);
    repeat (5) begin
      chk("b2b_hold_valid", bus.rsp_valid, 1);
      chk("b2b_hold_result", bus.rsp_result, 32'h40E0_0000);
      chk("b2b_hold_req_ready", bus.req_ready, 0);
      @(negedge clk);
    end
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    wait_accept(1'b0);
    wait_drain();
    chk("b2b_starts", start_cnt - base, 2);
    exp_ops = exp_ops + CW'(2);
    chk("b2b_ops_issued", ops_issued, exp_ops);

    // Timeout: fp_alu acks but never completes.
    hang = 1'b1;
    base = start_cnt;
    send(v_tmo, 1'b0);
    n = 0;
    do @(negedge clk); while (!alu_start && ++n < 20);
    n = 0;
    do begin @(negedge clk); if (!bus.rsp_valid) n++; end while (!bus.rsp_valid && n < 50);
    chk("tmo_wait_cycles", n, TMO);
    wait_drain();
    exp_ops = exp_ops + CW'(1);
    chk("tmo_ops_issued", ops_issued, exp_ops);
    hang = 1'b0;
    n = 0;
    while (!alu_ready && n < 50) begin @(posedge clk); n++; end
    #1;

    // Reset during WAIT_DONE: outputs drop at once, op abandoned.
    hang = 1'b1;
    send(v_add, 1'b0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1 chk_all_zero("midrst");
    sb_q.delete();
    exp_ops = '0;
    @(posedge clk); #1 reset = 1'b1;
    base = start_cnt;
    bus.req_a = v_add.a; bus.req_b = v_add.b; bus.req_op = v_add.op; bus.req_valid = 1'b1;
    sb_q.push_back(v_add);
    repeat (4) begin
      @(negedge clk);
      chk("midrst_no_accept", bus.req_ready, 0);
      chk("midrst_no_rsp", bus.rsp_valid, 0);
    end
    @(posedge clk); #1 hang = 1'b0;
    wait_accept(1'b0);
    wait_drain();
    chk("midrst_starts", start_cnt - base, 1);
    exp_ops = exp_ops + CW'(1);
    chk("midrst_ops_issued", ops_issued, exp_ops);

    // Counter wrap (CNT_W = 3).
    for (int k = 0; k < 9; k++) begin
      send(v_add, 1'b0);
      wait_drain();
      exp_ops = exp_ops + CW'(1);
    end
    chk("wrap_ops_issued", ops_issued, exp_ops);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
